multicycle_control: RTL
=======================

# multicycle_control

Multi-cycle control unit for the 32-bit microprocessor datapath; it is the producer of the ALU's `opCode` and operand-select signals. It sequences each instruction through fetch, decode, execute, memory and write-back states, drives all datapath enables, and waits on a memory ready handshake. It also counts retired instructions and flags illegal encodings.

## Interface
Parameters:
- `COUNT_WIDTH`, 32, width of retired-instruction counter.

Ports:
- `clk` in 1: single clock; all state changes on rising edge.
- `reset` in 1: asynchronous, active-high.
- `instr` in 32: instruction register contents (valid from DECODE onward).
- `aluZero` in 1: ALU result == 0, combinational from current ALU output.
- `memReady` in 1: memory completes the current read or write this cycle.
- `aluOpCode` out 6: ALU opcode, ADD=0, SUB=1, AND=2, OR=3, SLT=4.
- `aluSrcA` out 1: 0=PC, 1=register A.
- `aluSrcB` out 2: 0=register B, 1=constant 4, 2=sign-extended imm, 3=sign-extended imm<<2.
- `pcSource` out 2: 0=ALU result, 1=ALUOut register, 2=jump target.
- `pcWrite`, `irWrite`, `regWrite`, `memRead`, `memWrite` out 1 each: datapath enables.
- `iorD` out 1: memory address, 0=PC, 1=ALUOut.
- `regDst` out 1: 0=rt, 1=rd.
- `memToReg` out 1: 0=ALUOut, 1=memory data.
- `illegal` out 1: one-cycle pulse on an unsupported encoding.
- `instrCount` out COUNT_WIDTH: retired legal instructions.

## Operation
- Moore outputs decoded from the state. Exception: in FETCH, `irWrite`/`pcWrite` equal `memReady`; in BRANCH, `pcWrite` equals `aluZero`.
- In any state, every output not listed below is 0 and `aluOpCode`=ADD.
- Supported instructions: R-type (op 0x00; funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt); lw 0x23; sw 0x2B; beq 0x04; addi 0x08; j 0x02.
- States and outputs:
  - IDLE: all outputs 0. Goes to FETCH.
  - FETCH: memRead=1, iorD=0, aluSrcA=0, aluSrcB=1, ADD, pcSource=0. Stays in FETCH while memReady=0; goes to DECODE when memReady=1.
  - DECODE: aluSrcA=0, aluSrcB=3, ADD (computes branch target).
    - R-type/addi → EXECUTE; lw/sw → MEMADDR; beq → BRANCH; j → JUMP.
    - Anything else: `illegal`=1 for this cycle, then FETCH.
  - EXECUTE: aluSrcA=1; aluSrcB=0 with the funct-mapped opcode (R-type), or aluSrcB=2 with ADD (addi). Goes to ALUWB.
  - ALUWB: regWrite=1, memToReg=0, regDst=1 for R-type / 0 for addi. Retires; goes to FETCH.
  - MEMADDR: aluSrcA=1, aluSrcB=2, ADD. lw → MEMREAD; sw → MEMWRITE.
  - MEMREAD: memRead=1, iorD=1. Holds until memReady=1, then goes to MEMWB.
  - MEMWB: regWrite=1, memToReg=1, regDst=0. Retires; goes to FETCH.
  - MEMWRITE: memWrite=1, iorD=1. Holds until memReady=1; that cycle retires and goes to FETCH.
  - BRANCH: aluSrcA=1, aluSrcB=0, SUB, pcSource=1, pcWrite=aluZero. Retires; goes to FETCH.
  - JUMP: pcSource=2, pcWrite=1. Retires; goes to FETCH.
- `instrCount` increments by 1 on each retiring cycle and wraps from all-ones to 0. Illegal instructions do not count.

## Timing
- Reset: state=IDLE, `instrCount`=0, all outputs 0, `illegal`=0. Applies immediately, including mid-instruction; any memRead/memWrite is dropped at once.
- First FETCH is the cycle after reset deasserts.
- Cycle counts with memReady=1 on first request, including FETCH:
  - beq, j: 3.
  - R-type, addi, sw: 4.
  - lw: 5.
- Each cycle memReady is low in FETCH, MEMREAD or MEMWRITE adds one cycle. memRead/memWrite stay asserted and the address select stays stable while waiting.
- `instrCount` updates on the clock edge that ends the retiring cycle.

## Structure
- Shared package holds:
  - ALU opcode constants (the same values the ALU decodes).
  - Instruction opcode and funct constants.
  - State encoding.
  - aluSrcB and pcSource select encodings.
- One combinational sub-module, `alu_op_decoder`: maps funct to `aluOpCode` plus a legal flag. It is used in DECODE (legality) and EXECUTE (opcode).

## Test plan
- Reset mid-MEMREAD with memRead=1 → memRead=0 and all outputs 0 immediately, `instrCount`=0; FETCH one cycle after deassert.
- R-type funct 0x2A, memReady tied 1 → in EXECUTE aluOpCode=4, aluSrcA=1, aluSrcB=0; ALUWB has regWrite=1, regDst=1; `instrCount` +1 after 4 cycles.
- lw with memReady low for 3 cycles in MEMREAD → memRead=1, iorD=1 held; instruction takes 8 cycles; MEMWB has memToReg=1.
- beq with aluZero=1 → BRANCH has pcWrite=1, pcSource=1, aluOpCode=1. With aluZero=0 → pcWrite=0. Both take 3 cycles and both increment the count.
- Opcode 0x3F, or R-type funct 0x27 → `illegal` one-cycle pulse in DECODE, no regWrite/memWrite, next state FETCH, count unchanged.
- Preload count to 0xFFFFFFFF via 2^32-1 retirements (or a forced state), then retire a j → `instrCount`=0.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle control unit:
// ALU opcodes, instruction opcode/funct values, FSM states, mux selects.
package multicycle_control_pkg;

  localparam logic [5:0] ALU_ADD = 6'd0;
  localparam logic [5:0] ALU_SUB = 6'd1;
  localparam logic [5:0] ALU_AND = 6'd2;
  localparam logic [5:0] ALU_OR  = 6'd3;
  localparam logic [5:0] ALU_SLT = 6'd4;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [1:0] SRCB_REG   = 2'd0;
  localparam logic [1:0] SRCB_FOUR  = 2'd1;
  localparam logic [1:0] SRCB_IMM   = 2'd2;
  localparam logic [1:0] SRCB_IMMSH = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_ALUWB,
    S_MEMADDR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_BRANCH,
    S_JUMP
  } state_t;

endpackage

// File: rtl/multicycle_control_alu_op_decoder.sv
// alu_op_decoder: maps R-type funct to ALU opcode plus legal flag.
// Ports: i_funct (6) in; o_alu_op (6), o_legal (1) out.
module alu_op_decoder
  import multicycle_control_pkg::*;
(
  input  logic [5:0] i_funct,
  output logic [5:0] o_alu_op,
  output logic       o_legal
);

  always_comb begin
    o_alu_op = ALU_ADD;
    o_legal  = 1'b1;
    case (i_funct)
      FN_ADD:  o_alu_op = ALU_ADD;
      FN_SUB:  o_alu_op = ALU_SUB;
      FN_AND:  o_alu_op = ALU_AND;
      FN_OR:   o_alu_op = ALU_OR;
      FN_SLT:  o_alu_op = ALU_SLT;
      default: o_legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/mem/wb,
// drives datapath enables and mux selects, counts retired instructions.
// Ports: clk, reset (async high), instr, aluZero, memReady in;
// ALU/mux selects, datapath enables, illegal, instrCount out.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            instr,
  input  logic                   aluZero,
  input  logic                   memReady,
  output logic [5:0]             aluOpCode,
  output logic                   aluSrcA,
  output logic [1:0]             aluSrcB,
  output logic [1:0]             pcSource,
  output logic                   pcWrite,
  output logic                   irWrite,
  output logic                   regWrite,
  output logic                   memRead,
  output logic                   memWrite,
  output logic                   iorD,
  output logic                   regDst,
  output logic                   memToReg,
  output logic                   illegal,
  output logic [COUNT_WIDTH-1:0] instrCount
);

  state_t                 r_state;
  state_t                 w_next;
  logic [COUNT_WIDTH-1:0] r_count;
  logic                   w_retire;
  logic [5:0]             w_op;
  logic [5:0]             w_fn_op;
  logic                   w_fn_legal;
  logic                   w_is_r;
  logic                   w_unused;

  assign w_op     = instr[31:26];
  assign w_is_r   = (w_op == OP_RTYPE);
  assign w_unused = ^instr[25:6];

  alu_op_decoder u_dec (
    .i_funct  (instr[5:0]),
    .o_alu_op (w_fn_op),
    .o_legal  (w_fn_legal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_count <= '0;
    else if (w_retire) r_count <= r_count + COUNT_WIDTH'(1);
  end

  assign instrCount = r_count;

  always_comb begin
    w_next    = r_state;
    w_retire  = 1'b0;
    aluOpCode = ALU_ADD;
    aluSrcA   = 1'b0;
    aluSrcB   = SRCB_REG;
    pcSource  = PCSRC_ALU;
    pcWrite   = 1'b0;
    irWrite   = 1'b0;
    regWrite  = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    iorD      = 1'b0;
    regDst    = 1'b0;
    memToReg  = 1'b0;
    illegal   = 1'b0;
    unique case (r_state)
      S_IDLE: w_next = S_FETCH;
      S_FETCH: begin
        memRead = 1'b1;
        aluSrcB = SRCB_FOUR;
        irWrite = memReady;
        pcWrite = memReady;
        if (memReady) w_next = S_DECODE;
      end
      S_DECODE: begin
        aluSrcB = SRCB_IMMSH;
        case (w_op)
          OP_RTYPE: begin
            if (w_fn_legal) begin
              w_next = S_EXECUTE;
            end else begin
              illegal = 1'b1;
              w_next  = S_FETCH;
            end
          end
          OP_ADDI:      w_next = S_EXECUTE;
          OP_LW, OP_SW: w_next = S_MEMADDR;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          default: begin
            illegal = 1'b1;
            w_next  = S_FETCH;
          end
        endcase
      end
      S_EXECUTE: begin
        aluSrcA = 1'b1;
        if (w_is_r) begin
          aluSrcB   = SRCB_REG;
          aluOpCode = w_fn_op;
        end else begin
          aluSrcB = SRCB_IMM;
        end
        w_next = S_ALUWB;
      end
      S_ALUWB: begin
        regWrite = 1'b1;
        regDst   = w_is_r;
        w_retire = 1'b1;
        w_next   = S_FETCH;
      end
      S_MEMADDR: begin
        aluSrcA = 1'b1;
        aluSrcB = SRCB_IMM;
        w_next  = (w_op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        memRead = 1'b1;
        iorD    = 1'b1;
        if (memReady) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        regWrite = 1'b1;
        memToReg = 1'b1;
        w_retire = 1'b1;
        w_next   = S_FETCH;
      end
      S_MEMWRITE: begin
        memWrite = 1'b1;
        iorD     = 1'b1;
        if (memReady) begin
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end
      end
      S_BRANCH: begin
        aluSrcA   = 1'b1;
        aluSrcB   = SRCB_REG;
        aluOpCode = ALU_SUB;
        pcSource  = PCSRC_ALUOUT;
        pcWrite   = aluZero;
        w_retire  = 1'b1;
        w_next    = S_FETCH;
      end
      S_JUMP: begin
        pcSource = PCSRC_JUMP;
        pcWrite  = 1'b1;
        w_retire = 1'b1;
        w_next   = S_FETCH;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule
